// File: rtl/rf_port_arbiter_if.sv
// Requester-side and register-file-side signals of the shared RF access port.
// The master modport belongs to the environment: the requesters plus the
// register file. The slave modport belongs to the arbiter.
interface rf_port_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_rs;
    logic [NREQ*AW-1:0] req_rt;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata_a;
    logic [DW-1:0]      rdata_b;
    logic               busy;
    logic [AW-1:0]      rf_rs;
    logic [AW-1:0]      rf_rt;
    logic [AW-1:0]      rf_rd;
    logic [DW-1:0]      rf_wdata;
    logic               rf_we;
    logic [DW-1:0]      rf_data_a;
    logic [DW-1:0]      rf_data_b;

    modport master (
        output req, req_we, req_rs, req_rt, req_rd, req_wdata,
        output rf_data_a, rf_data_b,
        input  gnt, ack, rdata_a, rdata_b, busy,
        input  rf_rs, rf_rt, rf_rd, rf_wdata, rf_we
    );

    modport slave (
        input  req, req_we, req_rs, req_rt, req_rd, req_wdata,
        input  rf_data_a, rf_data_b,
        output gnt, ack, rdata_a, rdata_b, busy,
        output rf_rs, rf_rt, rf_rd, rf_wdata, rf_we
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing the register file's single access port.
// Each granted transaction runs READ -> WRITE -> DONE, so reads always see
// pre-write contents. Writes to register 0 are suppressed.
module rf_port_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic               clk,
    input logic               rst,
    rf_port_arbiter_if.slave  bus
);
    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] pick_onehot;

    logic [AW-1:0]   sel_rs;
    logic [AW-1:0]   sel_rt;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    logic [AW-1:0]   t_rd;
    logic [DW-1:0]   t_wdata;
    logic            t_we;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NR);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Select the chosen requester's fields and one-hot grant.
    always_comb begin
        pick_onehot = '0;
        sel_rs      = '0;
        sel_rt      = '0;
        sel_rd      = '0;
        sel_wdata   = '0;
        sel_we      = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (IW'(k) == pick) begin
                pick_onehot[k] = 1'b1;
                sel_rs         = bus.req_rs[k*AW +: AW];
                sel_rt         = bus.req_rt[k*AW +: AW];
                sel_rd         = bus.req_rd[k*AW +: AW];
                sel_wdata      = bus.req_wdata[k*DW +: DW];
                sel_we         = bus.req_we[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one step per cycle once granted, no stalls.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Transaction datapath. The read addresses go straight into the rf_rs/rf_rt
    // registers at grant, so they are already the latched values during READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.gnt      <= '0;
            bus.ack      <= '0;
            bus.rdata_a  <= '0;
            bus.rdata_b  <= '0;
            bus.rf_rs    <= '0;
            bus.rf_rt    <= '0;
            bus.rf_rd    <= '0;
            bus.rf_wdata <= '0;
            bus.rf_we    <= 1'b0;
            rr_ptr       <= '0;
            owner        <= '0;
            t_rd         <= '0;
            t_wdata      <= '0;
            t_we         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        bus.gnt   <= pick_onehot;
                        owner     <= pick;
                        bus.rf_rs <= sel_rs;
                        bus.rf_rt <= sel_rt;
                        t_rd      <= sel_rd;
                        t_wdata   <= sel_wdata;
                        t_we      <= sel_we;
                    end
                end
                READ: begin
                    bus.rdata_a  <= bus.rf_data_a;
                    bus.rdata_b  <= bus.rf_data_b;
                    bus.rf_rd    <= t_rd;
                    bus.rf_wdata <= t_wdata;
                    bus.rf_we    <= t_we && (t_rd != '0);
                end
                WRITE: begin
                    bus.rf_we <= 1'b0;
                    bus.ack   <= bus.gnt;
                end
                DONE: begin
                    bus.ack <= '0;
                    bus.gnt <= '0;
                    rr_ptr  <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Randomized bench for rf_port_arbiter with a transaction-level reference
// model: each grant is a timeline anchored at the arbitration cycle.
module tb_rf_port_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural register file behind the shared port.
    logic [DW-1:0] rf_mem [32];
    logic          ld_en   = 1'b0;
    logic [4:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) rf_mem[ld_addr] <= ld_data;
        else if (bus.rf_we) rf_mem[bus.rf_rd] <= bus.rf_wdata;
    end
    assign bus.rf_data_a = rf_mem[bus.rf_rs];
    assign bus.rf_data_b = rf_mem[bus.rf_rt];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [DW-1:0] m_regs [32];
    int            rr = 0;
    bit            active = 1'b0;
    int            s = 0;
    int            owner = 0;
    logic [AW-1:0] t_rs, t_rt, t_rd;
    logic [DW-1:0] t_wd;
    bit            t_we;
    logic [DW-1:0] m_rda = '0, m_rdb = '0;
    logic [AW-1:0] m_rfrs = '0, m_rfrt = '0, m_rfrd = '0;
    logic [DW-1:0] m_rfwd = '0;

    // Requester drivers.
    bit            pend [NREQ];
    logic [AW-1:0] q_rs [NREQ];
    logic [AW-1:0] q_rt [NREQ];
    logic [AW-1:0] q_rd [NREQ];
    logic [DW-1:0] q_wd [NREQ];
    bit            q_we [NREQ];
    bit            no_new = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic new_fields(input int i);
        q_rs[i] = AW'($urandom_range(0, 31));
        q_rt[i] = AW'($urandom_range(0, 31));
        q_rd[i] = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) q_rs[i] = q_rd[i];
        q_we[i] = ($urandom_range(0, 1) == 1);
        q_wd[i] = $urandom;
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                   = pend[i];
            bus.req_we[i]                = q_we[i];
            bus.req_rs[i*AW +: AW]       = q_rs[i];
            bus.req_rt[i*AW +: AW]       = q_rt[i];
            bus.req_rd[i*AW +: AW]       = q_rd[i];
            bus.req_wdata[i*DW +: DW]    = q_wd[i];
        end
    endtask

    // One cycle at the falling edge: check cycle n, drive inputs, then decide
    // what the coming rising edge does.
    task automatic step(input int n);
        int              d;
        bit              idle_now;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_ack;
        bit              exp_we;
        d        = active ? n - s : -1;
        idle_now = !active;
        exp_gnt  = '0;
        exp_ack  = '0;
        exp_we   = 1'b0;
        if (active && d >= 1 && d <= 3) exp_gnt[owner] = 1'b1;
        if (active && d == 3) exp_ack[owner] = 1'b1;
        if (active && d == 1) begin
            m_rfrs = t_rs;
            m_rfrt = t_rt;
        end
        if (active && d == 2) begin
            m_rda  = m_regs[t_rs];
            m_rdb  = m_regs[t_rt];
            m_rfrd = t_rd;
            m_rfwd = t_wd;
            exp_we = t_we && (t_rd != '0);
        end
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("ack", 32'(bus.ack), 32'(exp_ack));
        check("busy", 32'(bus.busy), 32'(active && d >= 1 && d <= 3));
        check("rf_we", 32'(bus.rf_we), 32'(exp_we));
        check("rf_rs", 32'(bus.rf_rs), 32'(m_rfrs));
        check("rf_rt", 32'(bus.rf_rt), 32'(m_rfrt));
        check("rf_rd", 32'(bus.rf_rd), 32'(m_rfrd));
        check("rf_wdata", bus.rf_wdata, m_rfwd);
        check("rdata_a", bus.rdata_a, m_rda);
        check("rdata_b", bus.rdata_b, m_rdb);
        if (active && d == 3) begin
            if (t_we && t_rd != '0) m_regs[t_rd] = t_wd;
            rr     = (owner + 1) % NREQ;
            active = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ack[i]) begin
                if (!no_new && $urandom_range(0, 2) == 0) new_fields(i);
                else pend[i] = 1'b0;
            end else if (exp_gnt[i]) begin
                if ($urandom_range(0, 1) == 0) new_fields(i);
            end else if (pend[i]) begin
                if (!no_new && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
            end else if (!no_new && $urandom_range(0, 3) == 0) begin
                pend[i] = 1'b1;
                new_fields(i);
            end
        end
        drive_bus();
        if (idle_now) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (rr + k) % NREQ;
                if (!active && pend[j]) begin
                    active = 1'b1;
                    s      = n;
                    owner  = j;
                    t_rs   = q_rs[j];
                    t_rt   = q_rt[j];
                    t_rd   = q_rd[j];
                    t_wd   = q_wd[j];
                    t_we   = q_we[j];
                end
            end
        end
    endtask

    initial begin
        int n;
        int pending_cnt;
        int guard;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            q_rs[i] = '0; q_rt[i] = '0; q_rd[i] = '0; q_wd[i] = '0; q_we[i] = 1'b0;
        end
        drive_bus();
        rst = 1'b0;
        // Preload the register file while in reset.
        ld_en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ld_addr = 5'(a);
            ld_data = (a == 0) ? '0 : $urandom;
            m_regs[a] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_rf_we", 32'(bus.rf_we), 0);
        check("rst_rdata_a", bus.rdata_a, 0);
        check("rst_rf_rs", 32'(bus.rf_rs), 0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic.
        n = 0;
        for (int c = 0; c < NCYC; c++) begin
            step(n);
            n++;
            @(negedge clk);
        end

        // Drain outstanding requests.
        no_new = 1'b1;
        guard = 0;
        pending_cnt = 1;
        while (pending_cnt != 0 && guard < 200) begin
            step(n);
            n++;
            guard++;
            @(negedge clk);
            pending_cnt = int'(active);
            for (int i = 0; i < NREQ; i++) pending_cnt += int'(pend[i]);
        end
        check("drain_idle", 32'(pending_cnt), 0);

        // Directed write to r5 from requester 1, cut by reset during WRITE.
        pend[1] = 1'b1;
        q_rs[1] = 5'd5; q_rt[1] = 5'd6; q_rd[1] = 5'd5;
        q_wd[1] = 32'hDEADBEEF; q_we[1] = 1'b1;
        drive_bus();
        guard = 0;
        while (!(active && n - s == 2) && guard < 50) begin
            step(n);
            n++;
            guard++;
            @(negedge clk);
        end
        check("reach_write", 32'(active && n - s == 2), 1);
        step(n);
        #1 rst = 1'b0;
        #1;
        check("midrst_rf_we", 32'(bus.rf_we), 0);
        check("midrst_gnt", 32'(bus.gnt), 0);
        check("midrst_ack", 32'(bus.ack), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_rdata_b", bus.rdata_b, 0);
        active = 1'b0;
        rr = 0;
        m_rda = '0; m_rdb = '0;
        m_rfrs = '0; m_rfrt = '0; m_rfrd = '0; m_rfwd = '0;
        pend[0] = 1'b1;
        new_fields(0);
        drive_bus();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n++;
        for (int c = 0; c < 30; c++) begin
            step(n);
            n++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
